// File: rtl/bitrev_spi_pkg.sv
// Shared definitions for the bitrev SPI master.
//   state_e    : controller state encoding
//   FRAME_BITS : payload bits per transfer direction
package bitrev_spi_pkg;

  localparam int unsigned FRAME_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_SEND,
    ST_RECV,
    ST_RESP
  } state_e;

endpackage

// File: rtl/spi_sck_gen.sv
// SPI serial clock generator.
//   clk_i      : system clock
//   rst_ni     : asynchronous active-low reset
//   en_i       : run the divider; when low, sck is held low and the divider cleared
//   sck_o      : serial clock, low for CLK_DIV cycles then high for CLK_DIV cycles
//   rise_stb_o : one-cycle strobe on the edge where sck goes high
//   fall_stb_o : one-cycle strobe on the edge where sck goes low
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic sck_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);

  localparam int unsigned DW = $clog2(CLK_DIV + 1);

  logic [DW-1:0] div_q, div_d;
  logic          sck_q, sck_d;
  logic          wrap;

  assign wrap = en_i && (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    div_d = '0;
    sck_d = 1'b0;
    if (en_i) begin
      div_d = wrap ? '0 : div_q + DW'(1);
      sck_d = wrap ? ~sck_q : sck_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
      sck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o      = sck_q;
  assign rise_stb_o = wrap & ~sck_q;
  assign fall_stb_o = wrap &  sck_q;

endmodule

// File: rtl/bitrev_spi_ctrl.sv
// SPI master running one-byte frames against the bitrev slave.
// Frame: one flush pulse with ss high, 8 send pulses, 8 receive pulses.
//   clock/resetn           : system clock, asynchronous active-low reset
//   req_valid/ready/data   : request byte handshake (ready only in IDLE)
//   resp_valid/ready/data  : received byte handshake, data stable while valid
//   busy                   : frame in progress
//   spi_sck/ss/mosi/miso   : SPI pins (sck idles low, ss idles high, mosi idles 1)
module bitrev_spi_ctrl
  import bitrev_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned LSB_FIRST = 0
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [FRAME_BITS-1:0] req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [FRAME_BITS-1:0] resp_data,
  output logic                  busy,
  output logic                  spi_sck,
  output logic                  spi_ss,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int unsigned BW = $clog2(FRAME_BITS);

  state_e                state_q, state_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic                  mosi_q, mosi_d;
  logic                  ready_q, ready_d;
  logic                  resp_valid_q, resp_valid_d;

  logic                  sck_en, rise_stb, fall_stb;
  logic                  tx_bit;
  logic [FRAME_BITS-1:0] tx_shift, rx_shift;

  assign sck_en = (state_q == ST_FLUSH) || (state_q == ST_SEND) || (state_q == ST_RECV);

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk_i      (clock),
    .rst_ni     (resetn),
    .en_i       (sck_en),
    .sck_o      (spi_sck),
    .rise_stb_o (rise_stb),
    .fall_stb_o (fall_stb)
  );

  // One shift register serves both directions: it drains the request byte
  // during SEND and fills with miso samples during RECV.
  assign tx_bit   = (LSB_FIRST != 0) ? sh_q[0] : sh_q[FRAME_BITS-1];
  assign tx_shift = (LSB_FIRST != 0) ? {1'b0, sh_q[FRAME_BITS-1:1]}
                                     : {sh_q[FRAME_BITS-2:0], 1'b0};
  assign rx_shift = (LSB_FIRST != 0) ? {spi_miso, sh_q[FRAME_BITS-1:1]}
                                     : {sh_q[FRAME_BITS-2:0], spi_miso};

  always_comb begin
    state_d      = state_q;
    bit_d        = bit_q;
    sh_d         = sh_q;
    mosi_d       = mosi_q;
    resp_valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          state_d = ST_FLUSH;
          sh_d    = req_data;
        end
      end
      ST_FLUSH: begin
        // The flush pulse's falling edge opens the first send low half.
        if (fall_stb) begin
          state_d = ST_SEND;
          mosi_d  = tx_bit;
          sh_d    = tx_shift;
          bit_d   = '0;
        end
      end
      ST_SEND: begin
        if (fall_stb) begin
          if (bit_q == BW'(FRAME_BITS - 1)) begin
            state_d = ST_RECV;
            mosi_d  = 1'b1;
            bit_d   = '0;
          end else begin
            mosi_d = tx_bit;
            sh_d   = tx_shift;
            bit_d  = bit_q + BW'(1);
          end
        end
      end
      ST_RECV: begin
        // miso is only looked at here, so an undriven pin elsewhere is harmless.
        if (fall_stb) begin
          sh_d = rx_shift;
          if (bit_q == BW'(FRAME_BITS - 1)) begin
            state_d = ST_RESP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      ST_RESP: begin
        // resp_valid is registered: it rises the cycle after RESP is entered
        // and drops on the handshake edge.
        if (resp_valid_q && resp_ready) state_d = ST_IDLE;
        else                            resp_valid_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      bit_q        <= '0;
      sh_q         <= '0;
      mosi_q       <= 1'b1;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_q        <= bit_d;
      sh_q         <= sh_d;
      mosi_q       <= mosi_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = sh_q;
  assign busy       = (state_q != ST_IDLE);
  assign spi_ss     = !((state_q == ST_SEND) || (state_q == ST_RECV));
  assign spi_mosi   = mosi_q;

endmodule

// File: tb/tb_bitrev_spi_ctrl.sv
module tb_bitrev_spi_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       req_valid  [3];
  logic       req_ready  [3];
  logic [7:0] req_data   [3];
  logic       resp_valid [3];
  logic       resp_ready [3];
  logic [7:0] resp_data  [3];
  logic       busy       [3];
  logic       sck        [3];
  logic       ss         [3];
  logic       mosi       [3];

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  // Instance 0: CLK_DIV=2 MSB first; 1: CLK_DIV=2 LSB first; 2: CLK_DIV=1 MSB first.
  // Each gets a behavioural bitrev slave: after a flush pulse (ss high) it
  // captures 8 mosi bits on sck rises, then echoes them back in the same wire
  // order, changing miso on each rise. miso is X whenever it is not sending.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned DIV = (g == 2) ? 1 : 2;
    localparam int unsigned LSB = (g == 1) ? 1 : 0;
    logic       miso_w;
    int         scnt      = 0;
    logic [7:0] sbuf      = '0;
    logic       mv        = 1'b0;
    int         act_cnt   = 0;
    int         flush_cnt = 0;

    bitrev_spi_ctrl #(.CLK_DIV(DIV), .LSB_FIRST(LSB)) u_dut (
      .clock      (clk),
      .resetn     (resetn),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_data   (req_data[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_data  (resp_data[g]),
      .busy       (busy[g]),
      .spi_sck    (sck[g]),
      .spi_ss     (ss[g]),
      .spi_mosi   (mosi[g]),
      .spi_miso   (miso_w)
    );

    always @(posedge sck[g]) begin
      if (ss[g]) begin
        scnt      <= 0;
        flush_cnt <= flush_cnt + 1;
      end else begin
        if (scnt < 8)       sbuf[scnt[2:0]] <= mosi[g];
        else if (scnt < 16) mv <= sbuf[scnt[2:0]];
        scnt    <= scnt + 1;
        act_cnt <= act_cnt + 1;
      end
    end

    assign miso_w = (!ss[g] && scnt >= 9 && scnt <= 16) ? mv : 1'bx;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input int g, input logic [7:0] d, output int wait_cyc);
    req_valid[g] = 1'b1;
    req_data[g]  = d;
    wait_cyc     = 0;
    while (!req_ready[g] && wait_cyc < 200) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    check("req_accept", {31'd0, req_ready[g]}, 32'd1);
    @(posedge clk); #1;
    req_valid[g] = 1'b0;
  endtask

  task automatic wait_resp(input int g, output int lat);
    lat = 0;
    while (!resp_valid[g] && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    check("resp_seen", {31'd0, resp_valid[g]}, 32'd1);
  endtask

  task automatic take_resp(input int g);
    resp_ready[g] = 1'b1;
    @(posedge clk); #1;
    check("resp_dropped", {31'd0, resp_valid[g]}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, lat, a0, f0, n;
    logic [7:0] d;
    logic hs;

    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid[i]  = 1'b0;
      req_data[i]   = '0;
      resp_ready[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready",  {31'd0, req_ready[0]},  32'd0);
    check("rst_resp_valid", {31'd0, resp_valid[0]}, 32'd0);
    check("rst_resp_data",  {24'd0, resp_data[0]},  32'd0);
    check("rst_busy",       {31'd0, busy[0]},       32'd0);
    check("rst_sck",        {31'd0, sck[0]},        32'd0);
    check("rst_ss",         {31'd0, ss[0]},         32'd1);
    check("rst_mosi",       {31'd0, mosi[0]},       32'd1);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("idle_req_ready", {31'd0, req_ready[0]}, 32'd1);

    // 1: 0xA5 MSB first, latency and pulse counts
    a0 = g_dut[0].act_cnt;
    f0 = g_dut[0].flush_cnt;
    send_req(0, 8'hA5, w);
    check("busy_after_accept", {31'd0, busy[0]}, 32'd1);
    wait_resp(0, lat);
    check("latency_div2", lat, 32'd69);
    check("resp_a5", {24'd0, resp_data[0]}, 32'h0000_00A5);
    check("wire_a5", {24'd0, g_dut[0].sbuf}, 32'h0000_00A5);
    check("ss_low_pulses", g_dut[0].act_cnt - a0, 32'd16);
    check("flush_pulses", g_dut[0].flush_cnt - f0, 32'd1);
    check("resp_no_x", {31'd0, $isunknown(resp_data[0])}, 32'd0);
    take_resp(0);

    // 2: LSB first, back-to-back 0x01 then 0x80
    send_req(1, 8'h01, w);
    wait_resp(1, lat);
    check("resp_01", {24'd0, resp_data[1]}, 32'h0000_0001);
    check("wire_01", {24'd0, g_dut[1].sbuf}, 32'h0000_0001);
    take_resp(1);
    send_req(1, 8'h80, w);
    check("b2b_wait", w, 32'd0);
    wait_resp(1, lat);
    check("resp_80", {24'd0, resp_data[1]}, 32'h0000_0080);
    check("wire_80", {24'd0, g_dut[1].sbuf}, 32'h0000_0080);
    take_resp(1);

    // 3: response stall
    resp_ready[0] = 1'b0;
    send_req(0, 8'h5A, w);
    wait_resp(0, lat);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      check("stall_valid", {31'd0, resp_valid[0]}, 32'd1);
      check("stall_data",  {24'd0, resp_data[0]},  32'h0000_005A);
      check("stall_ready", {31'd0, req_ready[0]},  32'd0);
      check("stall_sck",   {31'd0, sck[0]},        32'd0);
      check("stall_ss",    {31'd0, ss[0]},         32'd1);
    end
    take_resp(0);

    // 4: reset during the 4th send bit, then a clean frame
    send_req(0, 8'hC3, w);
    repeat (17) @(posedge clk);
    #1;
    check("mid_ss_low", {31'd0, ss[0]}, 32'd0);
    resetn = 1'b0;
    #1;
    check("mrst_req_ready",  {31'd0, req_ready[0]},  32'd0);
    check("mrst_resp_valid", {31'd0, resp_valid[0]}, 32'd0);
    check("mrst_resp_data",  {24'd0, resp_data[0]},  32'd0);
    check("mrst_busy",       {31'd0, busy[0]},       32'd0);
    check("mrst_sck",        {31'd0, sck[0]},        32'd0);
    check("mrst_ss",         {31'd0, ss[0]},         32'd1);
    check("mrst_mosi",       {31'd0, mosi[0]},       32'd1);
    #1;
    resetn = 1'b1;
    send_req(0, 8'h3C, w);
    wait_resp(0, lat);
    check("resp_3c", {24'd0, resp_data[0]}, 32'h0000_003C);
    take_resp(0);

    // 5: CLK_DIV=1, random bytes with random resp_ready
    for (int i = 0; i < 200; i++) begin
      d = 8'($urandom_range(0, 255));
      resp_ready[2] = 1'b0;
      send_req(2, d, w);
      wait_resp(2, lat);
      check("latency_div1", lat, 32'd35);
      hs = 1'b0;
      n  = 0;
      while (!hs && n < 50) begin
        check("rnd_valid", {31'd0, resp_valid[2]}, 32'd1);
        check("rnd_data",  {24'd0, resp_data[2]},  {24'd0, d});
        resp_ready[2] = 1'($urandom_range(0, 1));
        hs = resp_ready[2];
        @(posedge clk); #1;
        n++;
      end
      check("rnd_handshake", {31'd0, hs}, 32'd1);
      check("rnd_no_dup", {31'd0, resp_valid[2]}, 32'd0);
      check("rnd_no_x", {31'd0, $isunknown(resp_data[2])}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
